// File: rtl/sparce_sasa_pkg.sv
// rtl/sparce_sasa_pkg.sv - shared types, field positions and helpers for the SASA skip table
package sparce_sasa_pkg;

    localparam int SKIP_CNT_W = 5;
    localparam int REG_IDX_W  = 5;
    localparam int COND_W     = 2;
    // Tags are stored at the widest size a 32-bit config word can stage.
    localparam int SASA_TAG_W = 30;

    localparam int ATTR_SKIP_LSB = 0;
    localparam int ATTR_RS1_LSB  = 5;
    localparam int ATTR_RS2_LSB  = 10;
    localparam int ATTR_COND_LSB = 15;

    typedef enum logic [COND_W-1:0] {
        COND_RS1 = 2'b00,
        COND_RS2 = 2'b01,
        COND_AND = 2'b10,
        COND_OR  = 2'b11
    } sasa_cond_t;

    typedef struct packed {
        logic                  valid;
        logic [SASA_TAG_W-1:0] tag;
        logic [SKIP_CNT_W-1:0] skip_cnt;
        logic [REG_IDX_W-1:0]  rs1;
        logic [REG_IDX_W-1:0]  rs2;
        sasa_cond_t            cond;
    } sasa_entry_t;

    function automatic sasa_entry_t make_entry(input logic [SASA_TAG_W-1:0] tag,
                                               input logic [31:0] attr);
        sasa_entry_t e;
        e.valid    = 1'b1;
        e.tag      = tag;
        e.skip_cnt = attr[ATTR_SKIP_LSB +: SKIP_CNT_W];
        e.rs1      = attr[ATTR_RS1_LSB +: REG_IDX_W];
        e.rs2      = attr[ATTR_RS2_LSB +: REG_IDX_W];
        e.cond     = sasa_cond_t'(attr[ATTR_COND_LSB +: COND_W]);
        return e;
    endfunction

endpackage

// File: rtl/sasa_match_enc.sv
// rtl/sasa_match_enc.sv - parallel tag compare with lowest-index priority encode
module sasa_match_enc #(
    parameter int N  = 16,
    parameter int TW = 30,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]         valid_i,
    input  logic [N-1:0][TW-1:0] tags_i,
    input  logic [TW-1:0]        key_i,
    output logic                 hit_o,
    output logic [IW-1:0]        idx_o
);

    always_comb begin
        hit_o = 1'b0;
        idx_o = '0;
        // Descending scan so the lowest matching index is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (valid_i[i] && (tags_i[i] == key_i)) begin
                hit_o = 1'b1;
                idx_o = IW'(i);
            end
        end
    end

endmodule

// File: rtl/sparce_sasa_table.sv
// rtl/sparce_sasa_table.sv - skip descriptor table with config staging and 1-cycle PC lookup
module sparce_sasa_table
    import sparce_sasa_pkg::*;
#(
    parameter int SASA_ENTRIES = 16,
    parameter int PC_W         = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cfg_wr_en,
    input  logic                  cfg_wr_sel,
    input  logic [31:0]           cfg_wr_data,
    input  logic                  cfg_clear,
    input  logic                  lookup_valid,
    input  logic [PC_W-1:0]       lookup_pc,
    output logic                  sasa_hit,
    output logic [SKIP_CNT_W-1:0] sasa_skip_cnt,
    output logic [REG_IDX_W-1:0]  sasa_rs1,
    output logic [REG_IDX_W-1:0]  sasa_rs2,
    output logic [COND_W-1:0]     sasa_cond,
    output logic                  sasa_full,
    output logic [15:0]           sasa_hit_count
);

    localparam int IDX_W = $clog2(SASA_ENTRIES);

    sasa_entry_t                                 ent_q [SASA_ENTRIES];
    logic [SASA_ENTRIES-1:0]                     valid_vec;
    logic [SASA_ENTRIES-1:0][SASA_TAG_W-1:0]     tag_vec;

    logic [SASA_TAG_W-1:0] staged_tag_q, staged_tag_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;

    logic                  hit_q, hit_d;
    logic [SKIP_CNT_W-1:0] skip_q, skip_d;
    logic [REG_IDX_W-1:0]  rs1_q, rs1_d;
    logic [REG_IDX_W-1:0]  rs2_q, rs2_d;
    sasa_cond_t            cond_q, cond_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  dd_hit, lk_hit, free_hit;
    logic [IDX_W-1:0]      dd_idx, lk_idx, free_idx, wr_idx;
    logic                  commit_go;
    sasa_entry_t           new_entry;
    logic [SASA_TAG_W-1:0] lk_key;
    logic                  unused_bits;

    assign unused_bits = ^{cfg_wr_data, lookup_pc[1:0]};

    always_comb begin
        for (int i = 0; i < SASA_ENTRIES; i++) begin
            valid_vec[i] = ent_q[i].valid;
            tag_vec[i]   = ent_q[i].tag;
        end
    end

    assign lk_key = SASA_TAG_W'(lookup_pc[PC_W-1:2]);

    sasa_match_enc #(.N(SASA_ENTRIES), .TW(SASA_TAG_W), .IW(IDX_W)) u_dedupe (
        .valid_i (valid_vec),
        .tags_i  (tag_vec),
        .key_i   (staged_tag_q),
        .hit_o   (dd_hit),
        .idx_o   (dd_idx)
    );

    sasa_match_enc #(.N(SASA_ENTRIES), .TW(SASA_TAG_W), .IW(IDX_W)) u_lookup (
        .valid_i (valid_vec),
        .tags_i  (tag_vec),
        .key_i   (lk_key),
        .hit_o   (lk_hit),
        .idx_o   (lk_idx)
    );

    always_comb begin
        free_hit = 1'b0;
        free_idx = '0;
        for (int i = SASA_ENTRIES - 1; i >= 0; i--) begin
            if (!valid_vec[i]) begin
                free_hit = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    assign sasa_full = &valid_vec;

    // A zero skip count would describe an empty region, so such commits are ignored.
    assign commit_go = cfg_wr_en && cfg_wr_sel && !cfg_clear
                    && (cfg_wr_data[ATTR_SKIP_LSB +: SKIP_CNT_W] != '0);
    assign new_entry = make_entry(staged_tag_q, cfg_wr_data);

    always_comb begin
        wr_idx       = ptr_q;
        ptr_d        = ptr_q;
        staged_tag_d = staged_tag_q;
        if (dd_hit) begin
            wr_idx = dd_idx;
        end else if (free_hit) begin
            wr_idx = free_idx;
        end
        if (cfg_clear) begin
            ptr_d = '0;
        end else if (commit_go && !dd_hit && !free_hit) begin
            ptr_d = ptr_q + IDX_W'(1);
        end
        if (cfg_wr_en && !cfg_wr_sel) begin
            staged_tag_d = SASA_TAG_W'(cfg_wr_data[PC_W-1:2]);
        end
    end

    always_comb begin
        hit_d  = lookup_valid && lk_hit;
        skip_d = '0;
        rs1_d  = '0;
        rs2_d  = '0;
        cond_d = COND_RS1;
        if (hit_d) begin
            skip_d = ent_q[lk_idx].skip_cnt;
            rs1_d  = ent_q[lk_idx].rs1;
            rs2_d  = ent_q[lk_idx].rs2;
            cond_d = ent_q[lk_idx].cond;
        end
        cnt_d = cnt_q;
        if (cfg_clear) begin
            cnt_d = '0;
        end else if (hit_d && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else if (cfg_clear) begin
            for (int i = 0; i < SASA_ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
        end else if (commit_go) begin
            ent_q[wr_idx] <= new_entry;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            staged_tag_q <= '0;
            ptr_q        <= '0;
            hit_q        <= 1'b0;
            skip_q       <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            cond_q       <= COND_RS1;
            cnt_q        <= '0;
        end else begin
            staged_tag_q <= staged_tag_d;
            ptr_q        <= ptr_d;
            hit_q        <= hit_d;
            skip_q       <= skip_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
            cond_q       <= cond_d;
            cnt_q        <= cnt_d;
        end
    end

    assign sasa_hit       = hit_q;
    assign sasa_skip_cnt  = skip_q;
    assign sasa_rs1       = rs1_q;
    assign sasa_rs2       = rs2_q;
    assign sasa_cond      = cond_q;
    assign sasa_hit_count = cnt_q;

endmodule

// File: doc/sparce_sasa_table.md
Name: sparce_sasa_table

Overview:
- Sparsity-Aware Skip Address (SASA) table. Holds software-configured skip descriptors.
- Each descriptor gives the PC of a skippable region, how many instructions to skip, and which source registers must be zero for the skip to be legal.
- Sits directly upstream of the sparce skip logic. Fetch presents its PC; one cycle later the table returns the matching descriptor, which the skip logic combines with register sparsity state.
- Configured by stores routed from the CSR/MMIO path.

Parameters:
- SASA_ENTRIES, 16: number of descriptors; power of two, 2..64.
- PC_W, 32: PC width; tag is PC[PC_W-1:2].

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- cfg_wr_en  in  1  configuration write strobe.
- cfg_wr_sel  in  1  0 = stage PC word, 1 = commit attribute word.
- cfg_wr_data  in  32  configuration write data.
- cfg_clear  in  1  invalidate all entries.
- lookup_valid  in  1  fetch PC valid this cycle.
- lookup_pc  in  PC_W  fetch PC.
- sasa_hit  out  1  registered: previous-cycle lookup matched a valid entry.
- sasa_skip_cnt  out  5  registered: instructions to skip (1..31).
- sasa_rs1  out  5  registered: first condition register.
- sasa_rs2  out  5  registered: second condition register.
- sasa_cond  out  2  registered: 00 rs1==0, 01 rs2==0, 10 both zero, 11 either zero.
- sasa_full  out  1  all entries valid.
- sasa_hit_count  out  16  saturating count of hits since reset/clear.

Behaviour:
- Reset (RST=1 at edge):
  - all valid bits 0, staged PC 0, allocation pointer 0.
  - sasa_hit, sasa_skip_cnt, sasa_rs1, sasa_rs2, sasa_cond, sasa_hit_count all 0.
  - sasa_full 0.
  - An in-progress stage/commit sequence is discarded.
- Stage (cfg_wr_en=1, sel=0):
  - staged_tag <= data[PC_W-1:2]; data[1:0] ignored.
  - Repeated stages overwrite; the last one wins.
- Commit (cfg_wr_en=1, sel=1), attribute word fields:
  - [4:0] skip count; [9:5] rs1; [14:10] rs2; [16:15] cond; [31:17] ignored.
  - skip count 0: commit is a no-op; no entry or pointer change.
  - If a valid entry already holds staged_tag, that entry is overwritten in place. Pointer unchanged.
  - Otherwise, write into the lowest-index invalid entry if one exists. Pointer unchanged.
  - Otherwise (table full), write into the entry at the allocation pointer. Pointer increments, wrapping SASA_ENTRIES-1 -> 0.
  - Written entry is valid=1.
- Clear:
  - cfg_clear=1 invalidates all entries, resets the pointer to 0, and zeroes sasa_hit_count next edge.
  - Clear has priority over a same-cycle commit, which is dropped.
  - Staged PC is kept.
- Lookup:
  - Latency 1. If lookup_valid at edge N, outputs at N+1 reflect a tag compare of lookup_pc[PC_W-1:2] against every valid entry, using table contents before edge N's write.
  - Same-cycle commit and lookup of the same PC: the lookup sees the old contents.
  - At most one entry matches, guaranteed by dedupe on commit. The priority encoder still selects the lowest index.
  - On miss or lookup_valid=0: sasa_hit=0 and the other descriptor outputs are 0.
  - Lookup during clear: the result is computed from pre-clear contents; the next cycle sees an empty table.
- sasa_hit_count:
  - +1 on each registered hit, saturating at 16'hFFFF.
  - Clear and reset take priority over increment.
- sasa_full: combinational AND of valid bits.
- No stall or backpressure: config and lookup are always accepted.

Decomposition:
- Package sparce_sasa_pkg:
  - sasa_cond_t enum: COND_RS1, COND_RS2, COND_AND, COND_OR.
  - sasa_entry_t struct: valid, tag, skip_cnt, rs1, rs2, cond.
  - Attribute-word field bit-position constants.
  - SKIP_CNT_W = 5.
- Sub-module sasa_match_enc: parameterised parallel tag compare plus lowest-index priority encoder. Returns hit and index. Instantiated twice:
  - against staged_tag for commit dedupe;
  - against lookup_pc for lookup.
- Free-slot finder is inline logic.

Test Plan:
- Reset then lookup 0x0000_1000 -> sasa_hit=0, all outputs 0, sasa_full=0, hit_count=0.
- Stage 0x0000_1040, commit 0x0001_2C63 (skip=3, rs1=3, rs2=11, cond=10), then lookup 0x0000_1040 -> next cycle hit=1, skip_cnt=3, rs1=3, rs2=11, cond=10; lookup 0x0000_1044 -> hit=0.
- Re-commit PC 0x1040 with skip=7 -> same entry updated, no new slot used; lookup returns skip_cnt=7.
- Fill 16 distinct PCs 0x2000+4i -> sasa_full=1.
  - Commit new PC 0x3000 -> replaces entry 0 (PC 0x2000 now misses), pointer=1.
  - Next new PC replaces entry 1.
- Same-cycle commit of new PC 0x4000 and lookup 0x4000 -> hit=0; lookup next cycle -> hit=1.
- Assert cfg_clear and commit in the same cycle -> commit dropped, all lookups miss, hit_count=0.
  - Commit with skip count 0 -> no entry allocated.
  - Apply 70000 hits -> hit_count saturates at 0xFFFF.
